dlx_data_ram: RTL and testbench
===============================

Name: dlx_data_ram

Overview:
Parametrised, word-addressed data memory for the DLX load/store path, replacing the fixed 64x32 RAM.
- Adds a request/acknowledge handshake and per-byte write enables.
- After reset, a sequencer clears the array one word per cycle; the block reports busy until the clear finishes.
- Keeps the debug observation ports used by the testbench (last address and its pre-write contents).

Parameters:
DATA_W, 32, word width in bits; multiple of 8
ADDR_W, 32, width of adr_i
DEPTH, 64, number of words; power of 2, >=2; IDX_W = clog2(DEPTH)
CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to IDLE (contents undefined)

Ports:
clk_i  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_i  in  1  access request, sampled each cycle
we_i  in  1  1 = write, 0 = read; qualified by req_i
be_i  in  DATA_W/8  byte-lane write enables; ignored on reads
adr_i  in  ADDR_W  word address
data_i  in  DATA_W  write data
data_o  out  DATA_W  read data / old word, valid while ack_o=1
ack_o  out  1  one-cycle pulse, one cycle after an accepted request
busy_o  out  1  clear in progress; requests are not accepted
err_o  out  1  out-of-range flag, valid with ack_o (see Optional Feature)
mem_addr_in_use  out  ADDR_W  adr_i of the last accepted request
mem_addr_in_use_value  out  DATA_W  pre-write word at that address

Behaviour:
- One clock (clk_i); reset is synchronous and active-high.
- Reset values:
  - data_o=0, ack_o=0, err_o=0, mem_addr_in_use=0, mem_addr_in_use_value=0.
  - clear counter=0.
  - busy_o=1 if CLEAR_ON_RESET, else 0.
- States: CLEAR, IDLE. Reset enters CLEAR if CLEAR_ON_RESET, else IDLE.
- CLEAR:
  - Writes 0 to mem[cnt] each cycle, cnt increments.
  - At cnt==DEPTH-1, writes the last word and moves to IDLE next cycle. busy_o drops in the first IDLE cycle.
  - The clear takes exactly DEPTH cycles.
  - req_i is ignored: no ack, no write, debug ports hold.
- IDLE:
  - A request is accepted when req_i=1 and the state is IDLE.
  - The block accepts one access per cycle, and back-to-back requests are allowed.
- Accepted access at cycle N; all of the following appear at cycle N+1:
  - data_o = the word before any write at index adr_i[IDX_W-1:0] (read-before-write).
  - If we_i=1, each lane k with be_i[k]=1 takes data_i[8k+7:8k]; other lanes keep their value. be_i=0 with we_i=1 is a legal no-op write.
  - ack_o=1.
  - mem_addr_in_use = adr_i; mem_addr_in_use_value = the pre-write word.
- No accepted request: ack_o=0; data_o and the debug ports hold their values.
- Same-address back-to-back requests: a read in cycle N+1 after a write in cycle N returns the written data, because the array has updated.
- Reset mid-clear restarts at cnt=0.
- Reset in the cycle after an accepted request: ack_o=0 and no ack is issued for that request. A write already committed at the edge of cycle N remains.
- Wrap: only the low IDX_W address bits index the array unless RANGE_CHECK is compiled in.

Optional Feature:
Macro DLX_DATA_RAM_RANGE_CHECK_EN.
- Defined: an accepted request with adr_i >= DEPTH gives ack_o=1, err_o=1 and data_o=0. The write is suppressed. Debug ports still update; mem_addr_in_use_value=0.
- Undefined: err_o is tied to 0 and upper address bits are ignored, so the address wraps modulo DEPTH.

Decomposition:
- Package dlx_mem_pkg holds:
  - the state enum {ST_CLEAR, ST_IDLE};
  - default DATA_W/DEPTH constants;
  - a byte-lane merge function (old, new, be) -> word.
- Sub-module dlx_ram_clear_seq: the CLEAR/IDLE FSM plus clear counter. Outputs: busy, clr_we, clr_idx.
- Array, handshake and debug registers stay in the top module.

Test Plan:
- Reset with DEPTH=64 -> busy_o=1 for 64 cycles, then 0. A read of address 63 returns 0x00000000 and ack_o pulses once.
- req_i held high during CLEAR -> no ack_o and no write. After busy_o drops, a read of address 5 returns 0.
- Write 0xDEADBEEF to address 3 with be_i=4'b1111, then write 0x11223344 with be_i=4'b0101 -> second ack data_o=0xDEADBEEF; a following read returns 0xDE22BE44.
- Back-to-back: write 0xA5A5A5A5 to address 7, then read address 7 the next cycle -> read ack gives data_o=0xA5A5A5A5, mem_addr_in_use=7.
- Reset asserted at clear cnt=30 -> busy_o stays 1 for a full 64 cycles after reset release.
- RANGE_CHECK defined: write 0x1 to address 64 -> err_o=1, data_o=0, address 0 unchanged. Undefined: the same write lands at address 0, err_o=0.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// Purpose: shared types, default sizes and the byte-lane merge helper for the DLX data RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dlx_mem_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } clr_state_e;

    localparam int DLX_DATA_W = 32;
    localparam int DLX_DEPTH  = 64;

    // The merge helper works on the widest supported word; callers zero-extend
    // their operands and truncate the result to their own DATA_W.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Lane k of the result comes from new_w when be[k] is set, else from old_w.
    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] old_w,
        input logic [MAX_DATA_W-1:0] new_w,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int k = 0; k < MAX_BE_W; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dlx_ram_clear_seq.sv
// Purpose: post-reset clear sequencer for the DLX data RAM (CLEAR/IDLE FSM + word counter).
// Latency: DEPTH cycles of clear after reset release, then permanently idle until next reset.
// Backpressure: busy stays high for the whole clear; the parent refuses requests meanwhile.
//
// Ports: clk_i/reset (sync, active-high); busy = clear in progress;
//        clr_we/clr_idx = zero-write strobe and word index for the array.
module dlx_ram_clear_seq
    import dlx_mem_pkg::*;
#(
    parameter int DEPTH          = DLX_DEPTH,
    parameter int IDX_W          = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk_i,
    input  logic             reset,
    output logic             busy,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_idx
);

    clr_state_e       state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy    = 1'b1;
                clr_we  = 1'b1;
                cnt_nxt = cnt + IDX_W'(1);
                // Last word is zeroed this cycle; IDLE (busy low) starts next cycle.
                if (cnt == IDX_W'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign clr_idx = cnt;

endmodule

// File: rtl/dlx_data_ram.sv
// Purpose: word-addressed DLX data memory with req/ack handshake, byte enables and debug taps.
// Latency: ack_o/data_o/debug ports one cycle after an accepted request; one access per cycle.
// Backpressure: requests are dropped (no ack) while busy_o is high during the post-reset clear.
//
// Ports: clk_i, reset (sync, active-high); req_i/we_i/be_i/adr_i/data_i = request;
//        data_o/ack_o/err_o = response; busy_o = clear running;
//        mem_addr_in_use/_value = address of last accepted request and its pre-write word.
// Build option: define DLX_DATA_RAM_RANGE_CHECK_EN to flag addresses >= DEPTH with err_o
// (write suppressed, data_o=0); without it the address wraps modulo DEPTH and err_o is 0.
module dlx_data_ram
    import dlx_mem_pkg::*;
#(
    parameter int DATA_W         = DLX_DATA_W,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = DLX_DEPTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   adr_i,
    input  logic [DATA_W-1:0]   data_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                ack_o,
    output logic                busy_o,
    output logic                err_o,
    output logic [ADDR_W-1:0]   mem_addr_in_use,
    output logic [DATA_W-1:0]   mem_addr_in_use_value
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              oor;
    logic              wr_en;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] wr_word;

    dlx_ram_clear_seq #(
        .DEPTH          (DEPTH),
        .IDX_W          (IDX_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk_i   (clk_i),
        .reset   (reset),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    assign busy_o = busy;

    // A request coinciding with reset is not taken: it would otherwise write the
    // array without ever being acknowledged.
    assign accept = req_i & ~busy & ~reset;
    assign idx    = adr_i[IDX_W-1:0];

`ifdef DLX_DATA_RAM_RANGE_CHECK_EN
    assign oor = |(adr_i >> IDX_W);
`else
    assign oor = 1'b0;
`endif

    assign old_word = mem[idx];
    assign wr_en    = accept & we_i & ~oor;
    assign wr_word  = DATA_W'(merge_bytes(MAX_DATA_W'(old_word), MAX_DATA_W'(data_i),
                                          MAX_BE_W'(be_i)));

    // Array has no reset; its contents are defined only by the clear sequence.
    // Clear and access writes are exclusive because accept requires !busy.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            data_o                <= '0;
            ack_o                 <= 1'b0;
            err_o                 <= 1'b0;
            mem_addr_in_use       <= '0;
            mem_addr_in_use_value <= '0;
        end else begin
            ack_o <= accept;
            err_o <= accept & oor;
            if (accept) begin
                // Read-before-write: the response always carries the word as it was.
                data_o                <= oor ? '0 : old_word;
                mem_addr_in_use       <= adr_i;
                mem_addr_in_use_value <= oor ? '0 : old_word;
            end
        end
    end

endmodule

// File: tb/tb_dlx_data_ram.sv
// Purpose: self-checking bench for dlx_data_ram against an array-based reference model.
// Latency: expects every response one clock after the request edge.
// Backpressure: drives requests through the clear window and expects them to be ignored.
module tb_dlx_data_ram;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;

    logic          clk_i = 1'b0;
    logic          reset = 1'b1;
    logic          req_i = 1'b0;
    logic          we_i  = 1'b0;
    logic [DW/8-1:0] be_i = '0;
    logic [AW-1:0] adr_i  = '0;
    logic [DW-1:0] data_i = '0;
    logic [DW-1:0] data_o;
    logic          ack_o;
    logic          busy_o;
    logic          err_o;
    logic [AW-1:0] mem_addr_in_use;
    logic [DW-1:0] mem_addr_in_use_value;

    dlx_data_ram #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk_i                 (clk_i),
        .reset                 (reset),
        .req_i                 (req_i),
        .we_i                  (we_i),
        .be_i                  (be_i),
        .adr_i                 (adr_i),
        .data_i                (data_i),
        .data_o                (data_o),
        .ack_o                 (ack_o),
        .busy_o                (busy_o),
        .err_o                 (err_o),
        .mem_addr_in_use       (mem_addr_in_use),
        .mem_addr_in_use_value (mem_addr_in_use_value)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: plain word array plus the last expected response/debug values.
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_data;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_val;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_data = '0;
        exp_addr = '0;
        exp_val  = '0;
    endtask

    // Count cycles with busy_o high, starting from the sample just after the
    // last reset edge. req_i is kept high the whole time; no ack may appear.
    task automatic count_busy(input string tag, input int exp_cycles);
        int n;
        n = 0;
        req_i = 1'b1; we_i = 1'b1; be_i = '1; adr_i = 32'd5; data_i = 32'hFFFF_FFFF;
        while (busy_o === 1'b1 && n < 4 * DEPTH) begin
            n++;
            if (ack_o !== 1'b0) chk({tag, "_ack_in_clear"}, 64'(ack_o), 64'd0);
            @(posedge clk_i); #1;
        end
        req_i = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
        chk({tag, "_ack_after_clear"}, 64'(ack_o), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        model_clear();
        chk({tag, "_rst_data"},  64'(data_o), 64'd0);
        chk({tag, "_rst_ack"},   64'(ack_o),  64'd0);
        chk({tag, "_rst_err"},   64'(err_o),  64'd0);
        chk({tag, "_rst_busy"},  64'(busy_o), 64'd1);
        chk({tag, "_rst_addr"},  64'(mem_addr_in_use), 64'd0);
        chk({tag, "_rst_val"},   64'(mem_addr_in_use_value), 64'd0);
        reset = 1'b0;
    endtask

    // Present one request; it is accepted on the next edge and checked just after.
    // req_i is left asserted so consecutive calls form back-to-back traffic.
    task automatic access(input string tag, input logic w, input logic [3:0] b,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   idx;
        logic oor;
        req_i = 1'b1; we_i = w; be_i = b; adr_i = a; data_i = d;
        idx = int'(a % DEPTH);
`ifdef DLX_DATA_RAM_RANGE_CHECK_EN
        oor = (a >= DEPTH);
`else
        oor = 1'b0;
`endif
        exp_data = oor ? '0 : model[idx];
        exp_addr = a;
        exp_val  = exp_data;
        if (w && !oor) begin
            for (int k = 0; k < DW/8; k++) begin
                if (b[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            end
        end
        @(posedge clk_i); #1;
        chk({tag, "_ack"},  64'(ack_o),  64'd1);
        chk({tag, "_data"}, 64'(data_o), 64'(exp_data));
        chk({tag, "_err"},  64'(err_o),  64'(oor));
        chk({tag, "_addr"}, 64'(mem_addr_in_use), 64'(exp_addr));
        chk({tag, "_val"},  64'(mem_addr_in_use_value), 64'(exp_val));
    endtask

    task automatic idle(input string tag);
        req_i = 1'b0;
        we_i  = 1'($urandom);
        adr_i = $urandom;
        @(posedge clk_i); #1;
        chk({tag, "_ack"},  64'(ack_o),  64'd0);
        chk({tag, "_hold"}, 64'(data_o), 64'(exp_data));
        chk({tag, "_hold_addr"}, 64'(mem_addr_in_use), 64'(exp_addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, full clear with requests held high.
        do_reset("init");
        count_busy("clear1", DEPTH);

        // Top word reads zero; ack is a single pulse.
        access("rd63", 1'b0, 4'h0, 32'd63, 32'h0);
        chk("rd63_const", 64'(data_o), 64'd0);
        idle("after_rd63");
        access("rd5", 1'b0, 4'h0, 32'd5, 32'h0);
        chk("rd5_const", 64'(data_o), 64'd0);
        idle("after_rd5");

        // Byte-lane merge.
        access("wr3_full", 1'b1, 4'hF, 32'd3, 32'hDEAD_BEEF);
        access("wr3_part", 1'b1, 4'h5, 32'd3, 32'h1122_3344);
        chk("wr3_part_old", 64'(data_o), 64'hDEAD_BEEF);
        access("rd3", 1'b0, 4'h0, 32'd3, 32'h0);
        chk("rd3_merge", 64'(data_o), 64'hDE22_BE44);
        access("wr3_be0", 1'b1, 4'h0, 32'd3, 32'hFFFF_FFFF);
        access("rd3_again", 1'b0, 4'hF, 32'd3, 32'h0);
        chk("rd3_noop", 64'(data_o), 64'hDE22_BE44);
        idle("after_merge");

        // Back-to-back write then read of the same word.
        access("b2b_wr7", 1'b1, 4'hF, 32'd7, 32'hA5A5_A5A5);
        access("b2b_rd7", 1'b0, 4'h0, 32'd7, 32'h0);
        chk("b2b_rd7_const", 64'(data_o), 64'hA5A5_A5A5);
        chk("b2b_rd7_addr", 64'(mem_addr_in_use), 64'd7);
        idle("after_b2b");

        // Address beyond DEPTH: error flag or wrap onto word 0.
        access("wr64", 1'b1, 4'hF, 32'd64, 32'h0000_0001);
`ifdef DLX_DATA_RAM_RANGE_CHECK_EN
        chk("wr64_err_const", 64'(err_o), 64'd1);
`else
        chk("wr64_err_const", 64'(err_o), 64'd0);
`endif
        access("rd0", 1'b0, 4'h0, 32'd0, 32'h0);
        idle("after_range");

        // Randomized traffic with gaps, a mix of clustered and wide addresses.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 3) == 0) begin
                idle("rand_idle");
            end else begin
                a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                                : AW'($urandom_range(0, 2 * DEPTH - 1));
                access("rand", 1'($urandom), 4'($urandom), a, $urandom);
            end
        end
        idle("rand_end");

        // Reset in the middle of the clear restarts it from word 0.
        do_reset("mid");
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i); #1;
        end
        chk("mid_busy_at30", 64'(busy_o), 64'd1);
        do_reset("mid2");
        count_busy("clear2", DEPTH);
        access("post_rd7", 1'b0, 4'h0, 32'd7, 32'h0);
        chk("post_rd7_cleared", 64'(data_o), 64'd0);
        idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
